// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and its neighbours
// (HI/LO register file, control unit).
//   op_e    : mult/div operation encodings as carried on the 2-bit op field
//   HL_*    : HI/LO write-select codes
//   state_e : sequencer states of mul_div_unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  localparam logic [1:0] HL_NONE = 2'b00;
  localparam logic [1:0] HL_LO   = 2'b01;
  localparam logic [1:0] HL_HI   = 2'b10;
  localparam logic [1:0] HL_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and mul_div_unit.
//   start    : issue pulse
//   op       : operation (see muldiv_pkg::op_e)
//   busA     : rs operand (multiplicand / dividend)
//   busB     : rt operand (multiplier / divisor)
//   busy     : operation in flight, stalls the pipeline
//   done     : one-cycle result-valid pulse
//   result   : {HI, LO}
//   regToMul : HI/LO write select
// master = EX-stage side, slave = the unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     busA;
  logic [WIDTH-1:0]     busB;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [1:0]           regToMul;

  modport master (
    output start, op, busA, busB,
    input  busy, done, result, regToMul
  );

  modport slave (
    input  start, op, busA, busB,
    output busy, done, result, regToMul
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   is_div : 0 = shift-add multiply, 1 = restoring shift-subtract divide
//   work_i : 2*WIDTH+1 bit working register
//            multiply: {accumulator upper half incl. carry, multiplier/low product}
//            divide  : {remainder (WIDTH+1 bits), dividend/quotient}
//   opnd_i : multiplicand or divisor magnitude
//   work_o : working register after this step
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   work_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH:0]   work_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // Upper half never exceeds WIDTH bits, so the WIDTH+1 bit sum keeps the carry.
    sum    = work_i[2*WIDTH:WIDTH] + (work_i[0] ? {1'b0, opnd_i} : '0);
    // Remainder shifted left, next dividend bit brought in from the quotient side.
    rem_sh = {work_i[2*WIDTH-1:WIDTH], work_i[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, opnd_i};
    work_o = '0;
    if (is_div) begin
      if (diff[WIDTH+1]) begin
        work_o = {rem_sh, work_i[WIDTH-2:0], 1'b0};
      end else begin
        work_o = {diff[WIDTH:0], work_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      work_o = {1'b0, sum, work_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing {HI, LO} for the HI/LO file.
// Operands are reduced to magnitudes on issue, 32 radix-2 steps run in CALC,
// signs are restored in FIX and the result is presented for one cycle in DONE.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, aborts any operation
//   bus : mul_div_unit_if.slave (start/op/busA/busB in, busy/done/result/regToMul out)
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic                  is_div_q, is_div_d;
  logic [WIDTH-1:0]      opnd_q, opnd_d;
  logic [2*WIDTH:0]      work_q, work_d;
  logic [2*WIDTH:0]      step_work;
  logic                  neg_lo_q, neg_lo_d;
  logic                  neg_hi_q, neg_hi_d;
  logic                  divz_q, divz_d;
  logic [2*WIDTH-1:0]    result_q, result_d;

  op_e                   op_in;
  logic                  in_signed;
  logic                  in_div;
  logic                  sign_a;
  logic                  sign_b;

  // Magnitude of a signed operand; the most negative value maps to itself,
  // which is its correct magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] sx;
    sx = $signed(x);
    if (is_signed && (sx < 0)) begin
      return $unsigned(-sx);
    end
    return x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x,
                                                  input logic neg);
    return neg ? ('0 - x) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                     input logic neg);
    return neg ? ('0 - x) : x;
  endfunction

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div (is_div_q),
    .work_i (work_q),
    .opnd_i (opnd_q),
    .work_o (step_work)
  );

  always_comb begin
    op_in     = op_e'(bus.op);
    in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    in_div    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
    sign_a    = in_signed & bus.busA[WIDTH-1];
    sign_b    = in_signed & bus.busB[WIDTH-1];

    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    opnd_d    = opnd_q;
    work_d    = work_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    divz_d    = divz_q;
    result_d  = result_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = in_div;
          opnd_d   = magnitude(bus.busB, in_signed);
          work_d   = {{(WIDTH+1){1'b0}}, magnitude(bus.busA, in_signed)};
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          divz_d   = in_div && (bus.busB == '0);
        end
      end
      CALC: begin
        work_d = step_work;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        if (is_div_q) begin
          // A zero divisor leaves the dividend magnitude as remainder, so the
          // remainder sign fix restores busA; only the quotient needs forcing.
          result_d[2*WIDTH-1:WIDTH] = cond_neg_w(work_q[2*WIDTH-1:WIDTH], neg_hi_q);
          result_d[WIDTH-1:0]       = divz_q ? '1 : cond_neg_w(work_q[WIDTH-1:0], neg_lo_q);
        end else begin
          result_d = cond_neg_2w(work_q[2*WIDTH-1:0], neg_lo_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
    opnd_q   <= opnd_d;
    work_q   <= work_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    divz_q   <= divz_d;
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.regToMul = (state_q == DONE) ? HL_BOTH : HL_NONE;
  assign bus.result   = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed operations push their expected
// {HI, LO} on issue; a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   done_cnt;
  logic [63:0] exp_q[$];

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h with empty scoreboard", bus.result);
      end else begin
        check("result", bus.result, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e, input logic push);
    bus.start = 1'b1;
    bus.op    = op;
    bus.busA  = a;
    bus.busB  = b;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Follows one operation from the cycle after its issue edge up to done,
  // optionally poking start mid-CALC or chaining a new op in the DONE cycle.
  task automatic track(input int poke, input logic chain, input logic [1:0] nop,
                       input logic [31:0] na, input logic [31:0] nb,
                       input logic [63:0] nexp, input logic [63:0] cur);
    int busy_err;
    int done_err;
    busy_err = 0;
    done_err = 0;
    for (int k = 1; k <= 34; k++) begin
      if (k == poke) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.busA  = 32'd9;
        bus.busB  = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (k == 34 && chain) begin
        bus.start = 1'b1;
        bus.op    = nop;
        bus.busA  = na;
        bus.busB  = nb;
        exp_q.push_back(nexp);
      end
      @(negedge clk);
      if (k < 34) begin
        if (bus.busy !== 1'b1) busy_err++;
        if (bus.done !== 1'b0) done_err++;
      end else begin
        check("done_at_cycle34", bus.done, 1);
        check("regToMul_at_done", bus.regToMul, 2'b11);
        check("busy_at_done", bus.busy, 1);
      end
      @(posedge clk);
      #1;
    end
    check("busy_during_op", busy_err, 0);
    check("no_early_done", done_err, 0);
    bus.start = 1'b0;
    if (!chain) begin
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      check("idle_regToMul", bus.regToMul, 2'b00);
      check("result_held", bus.result, cur);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] e);
    issue(op, a, b, e, 1'b1);
    track(0, 1'b0, 2'b00, 32'd0, 32'd0, 64'd0, e);
  endtask

  initial begin
    int d0;
    total     = 0;
    bad       = 0;
    done_cnt  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.busA  = '0;
    bus.busB  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_regToMul", bus.regToMul, 2'b00);
    check("reset_result", bus.result, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run(2'b00, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB);
    run(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run(2'b01, 32'h12345678, 32'h00000010, 64'h00000001_23456780);
    run(2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    run(2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run(2'b11, 32'h00000007, 32'h00000002, 64'h00000001_00000003);
    run(2'b11, 32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF);
    run(2'b10, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF);
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

    // start pulsed in CALC cycle 5 must be ignored
    issue(2'b01, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b1);
    track(5, 1'b0, 2'b00, 32'd0, 32'd0, 64'd0, 64'h00000001_00000000);

    // back-to-back: second op issued in the DONE cycle
    issue(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1);
    track(0, 1'b1, 2'b00, 32'hFFFFFFFF, 32'd5, 64'hFFFFFFFF_FFFFFFFB, 64'd0);
    track(0, 1'b0, 2'b00, 32'd0, 32'd0, 64'd0, 64'hFFFFFFFF_FFFFFFFB);

    // reset in CALC cycle 10 aborts with no done and clears result
    issue(2'b01, 32'd3, 32'd5, 64'd0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      bus.start = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_result", bus.result, 64'd0);
    check("abort_done", bus.done, 0);
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt - d0, 0);

    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
